// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and output-stage state encoding for the 4-way round-robin arbiter.
// Imported by the arbiter top and by its data-select mux.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ       = 4;
  localparam int DEFAULT_WIDTH = 32;
  localparam int IDX_W         = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } grant_t;

endpackage

// File: rtl/mux4_rr_arbiter_mux4.sv
// Existing WIDTH-parameterised 4:1 multiplexer reused by the arbiter.
// It selects the payload of the granted requester.
module mux4
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    unique case (s)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four requesters share one registered WIDTH-bit output through valid/ready handshakes.
// A rotating pointer picks the grant; the output stage is a one-word EMPTY/FULL register.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  input  logic [WIDTH-1:0] req_data3,
  output logic [3:0]       req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  out_state_e       state_q;
  out_state_e       state_d;
  logic [IDX_W-1:0] ptr;
  grant_t           grant;
  logic             can_load;
  logic             accept;
  logic [WIDTH-1:0] sel_data;

  // Circular search from start: scan farthest-first so the nearest set bit wins.
  function automatic grant_t rr_pick(input logic [NUM_REQ-1:0] valid,
                                     input logic [IDX_W-1:0]   start);
    grant_t           g;
    logic [IDX_W-1:0] idx;
    g = '{found: 1'b0, idx: '0};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = start + IDX_W'(k);
      if (valid[idx]) begin
        g.found = 1'b1;
        g.idx   = idx;
      end
    end
    return g;
  endfunction

  assign out_valid = (state_q == ST_FULL);
  assign can_load  = (state_q == ST_EMPTY) || out_ready;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    grant     = rr_pick(req_valid, ptr);
    accept    = can_load && grant.found && !reset;
    req_ready = '0;
    if (accept) req_ready[grant.idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  mux4 #(.WIDTH(WIDTH)) u_mux (
    .d0 (req_data0),
    .d1 (req_data1),
    .d2 (req_data2),
    .d3 (req_data3),
    .s  (grant.idx),
    .y  (sel_data)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // A held word is simply discarded by reset; the downstream never sees a handshake for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_src  <= '0;
      ptr      <= '0;
    end else if (accept) begin
      out_data <= sel_data;
      out_src  <= grant.idx;
      ptr      <= grant.idx + 2'd1;
    end
  end

  assert property (@(posedge clk) $onehot0(req_ready));

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, single grant, wrap, back-to-back fairness,
// stall hold, and reset in the middle of a transfer.
module tb_mux4_rr_arbiter;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic [3:0]       req_valid;
  logic [WIDTH-1:0] req_data0, req_data1, req_data2, req_data3;
  logic [3:0]       req_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_src;
  logic             out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .req_data3 (req_data3),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; combinational outputs are sampled at the falling edge.
  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    req_valid = 4'b0000;
    out_ready = 1'b0;
    next_edge();
    next_edge();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    next_edge();
    mid_cycle();
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (out_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_out_data: got %h expected 00000000", out_data);
    end
    n_checks++;
    if (out_src !== 2'd0) begin
      n_fail++; $display("FAIL reset_out_src: got %0d expected 0", out_src);
    end
    next_edge();
    reset     = 1'b0;
    req_valid = 4'b0000;
  endtask

  // Single request from requester 2, then drain to EMPTY after exactly one valid cycle.
  task automatic test_single();
    req_valid = 4'b0100;
    req_data2 = 32'hCAFE0002;
    out_ready = 1'b1;
    mid_cycle();
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_req_ready: got %b expected 0100", req_ready);
    end
    next_edge();
    req_valid = 4'b0000;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hCAFE0002 || out_src !== 2'd2) begin
      n_fail++;
      $display("FAIL single_out: got v=%b d=%h s=%0d expected v=1 d=cafe0002 s=2", out_valid, out_data, out_src);
    end
    n_checks++;
    if (dut.ptr !== 2'd3) begin
      n_fail++; $display("FAIL single_ptr: got %0d expected 3", dut.ptr);
    end
    next_edge();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  // Pointer at 3 and only requester 0 valid: search wraps to 0, pointer becomes 1.
  task automatic test_wrap();
    req_valid = 4'b0001;
    req_data0 = 32'h0000_BEEF;
    out_ready = 1'b1;
    mid_cycle();
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL wrap_req_ready: got %b expected 0001", req_ready);
    end
    next_edge();
    req_valid = 4'b0000;
    n_checks++;
    if (out_src !== 2'd0 || out_data !== 32'h0000_BEEF) begin
      n_fail++; $display("FAIL wrap_out: got s=%0d d=%h expected s=0 d=0000beef", out_src, out_data);
    end
    n_checks++;
    if (dut.ptr !== 2'd1) begin
      n_fail++; $display("FAIL wrap_ptr: got %0d expected 1", dut.ptr);
    end
    next_edge();
  endtask

  // All four valid with downstream always ready: grants rotate 0,1,2,3,0,... one word per cycle.
  task automatic test_back_to_back();
    logic [1:0] exp_src;
    apply_reset();
    req_data0 = 32'h1000_0000;
    req_data1 = 32'h1000_0001;
    req_data2 = 32'h1000_0002;
    req_data3 = 32'h1000_0003;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_src = 2'(i % 4);
      mid_cycle();
      n_checks++;
      if (req_ready !== (4'b0001 << exp_src)) begin
        n_fail++; $display("FAIL b2b_req_ready[%0d]: got %b expected %b", i, req_ready, 4'b0001 << exp_src);
      end
      next_edge();
      n_checks++;
      if (out_valid !== 1'b1 || out_src !== exp_src || out_data !== (32'h1000_0000 + 32'(exp_src))) begin
        n_fail++;
        $display("FAIL b2b_out[%0d]: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                 i, out_valid, out_src, out_data, exp_src, 32'h1000_0000 + 32'(exp_src));
      end
    end
    req_valid = 4'b0000;
    next_edge();
  endtask

  // Hold FULL with out_src=1 under back-pressure, then release: requester 2 wins.
  task automatic test_stall();
    apply_reset();
    req_data0 = 32'hAAAA_0000;
    req_data1 = 32'hAAAA_0001;
    req_data2 = 32'hAAAA_0002;
    req_data3 = 32'hAAAA_0003;
    req_valid = 4'b0010;
    out_ready = 1'b0;
    next_edge();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      mid_cycle();
      n_checks++;
      if (req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL stall_req_ready[%0d]: got %b expected 0000", i, req_ready);
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 32'hAAAA_0001) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b s=%0d d=%h expected v=1 s=1 d=aaaa0001", i, out_valid, out_src, out_data);
      end
      next_edge();
    end
    out_ready = 1'b1;
    mid_cycle();
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL stall_release_ready: got %b expected 0100", req_ready);
    end
    next_edge();
    n_checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 32'hAAAA_0002) begin
      n_fail++;
      $display("FAIL stall_release_out: got v=%b s=%0d d=%h expected v=1 s=2 d=aaaa0002", out_valid, out_src, out_data);
    end
  endtask

  // Reset while FULL and requesters valid: word discarded, pointer back to 0, requester 0 first.
  task automatic test_reset_mid();
    out_ready = 1'b0;
    req_valid = 4'b1111;
    reset     = 1'b1;
    mid_cycle();
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_req_ready: got %b expected 0000", req_ready);
    end
    next_edge();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_src !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_out: got v=%b d=%h s=%0d expected v=0 d=00000000 s=0", out_valid, out_data, out_src);
    end
    n_checks++;
    if (dut.ptr !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_ptr: got %0d expected 0", dut.ptr);
    end
    reset     = 1'b0;
    out_ready = 1'b1;
    mid_cycle();
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid_first_grant: got %b expected 0001", req_ready);
    end
    next_edge();
    n_checks++;
    if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 32'hAAAA_0000) begin
      n_fail++;
      $display("FAIL rstmid_first_out: got v=%b s=%0d d=%h expected v=1 s=0 d=aaaa0000", out_valid, out_src, out_data);
    end
    req_valid = 4'b0000;
    next_edge();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'b0000;
    req_data0 = '0;
    req_data1 = '0;
    req_data2 = '0;
    req_data3 = '0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
